// File: rtl/posit_mac_seq_pkg.sv
// posit_mac_seq_pkg: shared FSM state and field widths
// for the dot-product MAC sequencer.
package posit_mac_seq_pkg;

  localparam int EXP_W  = 5;
  localparam int PREC_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_ISSUE,
    S_WAIT,
    S_RESULT
  } state_e;

endpackage

// File: rtl/posit_mac_seq.sv
// posit_mac_seq: issues one activation/weight pair per MAC op and holds the result.
// Optional result watchdog enabled by defining POSIT_MAC_SEQ_WATCHDOG_EN.
module posit_mac_seq
  import posit_mac_seq_pkg::*;
#(
  parameter int ACT_WIDTH      = 16,
  parameter int ACC_WIDTH      = 32,
  parameter int LEN_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           cfg_precision,
  input  logic [4:0]           cfg_exp_min,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ACT_WIDTH-1:0] in_act,
  input  logic                 in_w,
  output logic                 mac_set,
  output logic                 mac_valid,
  output logic [3:0]           mac_precision,
  output logic [ACT_WIDTH-1:0] mac_act,
  output logic                 mac_w,
  output logic [4:0]           mac_exp_min,
  output logic [31:0]          mac_fixed_point_acc,
  input  logic [4:0]           mac_exp_out,
  input  logic [ACC_WIDTH-1:0] mac_fixed_point_out,
  input  logic                 mac_done,
  input  logic                 mac_nar,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [4:0]           res_exp,
  output logic [ACC_WIDTH-1:0] res_acc,
  output logic                 res_nar,
  output logic                 res_err
);

  state_e               state_q, state_d;
  logic [PREC_W-1:0]    prec_q, prec_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0] cnt_inc;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [EXP_W-1:0]     exp_q, exp_d;
  logic [ACT_WIDTH-1:0] act_q, act_d;
  logic                 w_q, w_d;
  logic                 nar_q, nar_d;
  logic                 mv_q, mv_d;

`ifdef POSIT_MAC_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1) + 1;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    prec_d  = prec_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    exp_d   = exp_q;
    act_d   = act_q;
    w_d     = w_q;
    nar_d   = nar_q;
    mv_d    = 1'b0;
`ifdef POSIT_MAC_SEQ_WATCHDOG_EN
    wd_d    = wd_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          prec_d  = cfg_precision;
          len_d   = cfg_len;
          cnt_d   = '0;
          acc_d   = '0;
          exp_d   = cfg_exp_min;
          nar_d   = 1'b0;
`ifdef POSIT_MAC_SEQ_WATCHDOG_EN
          err_d   = 1'b0;
`endif
          state_d = S_CFG;
        end
      end
      S_CFG: begin
        state_d = (len_q == '0) ? S_RESULT : S_ISSUE;
      end
      S_ISSUE: begin
        if (in_valid) begin
          act_d   = in_act;
          w_d     = in_w;
          mv_d    = 1'b1;
`ifdef POSIT_MAC_SEQ_WATCHDOG_EN
          wd_d    = '0;
`endif
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mac_done) begin
          acc_d   = mac_fixed_point_out;
          exp_d   = mac_exp_out;
          nar_d   = nar_q | mac_nar;
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == len_q) ? S_RESULT : S_ISSUE;
        end
`ifdef POSIT_MAC_SEQ_WATCHDOG_EN
        else if (wd_q == WD_W'(TIMEOUT_CYCLES)) begin
          err_d   = 1'b1;
          state_d = S_RESULT;
        end else begin
          wd_d    = wd_q + 1'b1;
        end
`endif
      end
      S_RESULT: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      prec_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      exp_q   <= '0;
      act_q   <= '0;
      w_q     <= 1'b0;
      nar_q   <= 1'b0;
      mv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      prec_q  <= prec_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      exp_q   <= exp_d;
      act_q   <= act_d;
      w_q     <= w_d;
      nar_q   <= nar_d;
      mv_q    <= mv_d;
    end
  end

`ifdef POSIT_MAC_SEQ_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
  assign res_err = err_q;
`else
  assign res_err = 1'b0;
`endif

  assign busy          = (state_q != S_IDLE);
  assign in_ready      = (state_q == S_ISSUE);
  assign mac_set       = (state_q == S_CFG);
  assign res_valid     = (state_q == S_RESULT);
  assign mac_valid     = mv_q;
  assign mac_precision = prec_q;
  assign mac_act       = act_q;
  assign mac_w         = w_q;
  assign mac_exp_min   = exp_q;
  assign res_exp       = exp_q;
  assign res_acc       = acc_q;
  assign res_nar       = nar_q;

  // MAC port is fixed at 32 bits whatever the accumulator width
  generate
    if (ACC_WIDTH >= 32) begin : g_trunc
      assign mac_fixed_point_acc = acc_q[31:0];
    end else begin : g_zext
      assign mac_fixed_point_acc = {{(32-ACC_WIDTH){1'b0}}, acc_q};
    end
  endgenerate

endmodule

// File: tb/tb_posit_mac_seq.sv
// tb_posit_mac_seq: scoreboard bench with a behavioural MAC
// that adds 5 to the accumulator and 1 to the exponent per element.
module tb_posit_mac_seq;

  localparam int AW = 16;
  localparam int CW = 32;
  localparam int LW = 8;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [3:0]    cfg_precision;
  logic [4:0]    cfg_exp_min;
  logic [LW-1:0] cfg_len;
  logic          busy;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_act;
  logic          in_w;
  logic          mac_set;
  logic          mac_valid;
  logic [3:0]    mac_precision;
  logic [AW-1:0] mac_act;
  logic          mac_w;
  logic [4:0]    mac_exp_min;
  logic [31:0]   mac_fixed_point_acc;
  logic [4:0]    mac_exp_out;
  logic [CW-1:0] mac_fixed_point_out;
  logic          mac_done;
  logic          mac_nar;
  logic          res_valid;
  logic          res_ready;
  logic [4:0]    res_exp;
  logic [CW-1:0] res_acc;
  logic          res_nar;
  logic          res_err;

  always #5 clk = ~clk;

  posit_mac_seq #(
    .ACT_WIDTH(AW), .ACC_WIDTH(CW),
    .LEN_WIDTH(LW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_precision(cfg_precision),
    .cfg_exp_min(cfg_exp_min),
    .cfg_len(cfg_len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_act(in_act), .in_w(in_w),
    .mac_set(mac_set), .mac_valid(mac_valid),
    .mac_precision(mac_precision),
    .mac_act(mac_act), .mac_w(mac_w),
    .mac_exp_min(mac_exp_min),
    .mac_fixed_point_acc(mac_fixed_point_acc),
    .mac_exp_out(mac_exp_out),
    .mac_fixed_point_out(mac_fixed_point_out),
    .mac_done(mac_done), .mac_nar(mac_nar),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_exp(res_exp), .res_acc(res_acc),
    .res_nar(res_nar), .res_err(res_err)
  );

  typedef struct packed {
    logic [31:0] acc;
    logic [4:0]  ex;
    logic        nar;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int n_chk = 0;
  int n_fail = 0;
  int n_set = 0;
  int n_valid = 0;
  int elem_idx = 0;
  int nar_idx = -1;
  int hold_done = 0;
  int dly = 0;
  logic [31:0] p_acc;
  logic [4:0]  p_exp;
  logic        p_nar;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // behavioural MAC: answers two cycles after mac_valid
  initial begin
    mac_done = 1'b0;
    mac_nar = 1'b0;
    mac_exp_out = '0;
    mac_fixed_point_out = '0;
    forever begin
      @(negedge clk);
      mac_done = 1'b0;
      mac_nar = 1'b0;
      if (mac_set) n_set++;
      if (mac_valid) begin
        n_valid++;
        if (hold_done == 0) begin
          dly = 2;
          p_acc = mac_fixed_point_acc + 32'd5;
          p_exp = mac_exp_min + 5'd1;
          p_nar = (elem_idx == nar_idx);
        end
        elem_idx++;
      end else if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          mac_done = 1'b1;
          mac_nar = p_nar;
          mac_fixed_point_out = p_acc;
          mac_exp_out = p_exp;
        end
      end
    end
  end

  task automatic check_reset(input string pfx);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_in_ready"}, in_ready, 0);
    chk({pfx, "_mac_set"}, mac_set, 0);
    chk({pfx, "_mac_valid"}, mac_valid, 0);
    chk({pfx, "_res_valid"}, res_valid, 0);
    chk({pfx, "_res_nar"}, res_nar, 0);
    chk({pfx, "_res_err"}, res_err, 0);
    chk({pfx, "_res_acc"}, res_acc, 0);
    chk({pfx, "_mac_acc"}, mac_fixed_point_acc, 0);
    chk({pfx, "_mac_act"}, mac_act, 0);
    chk({pfx, "_mac_w"}, mac_w, 0);
    chk({pfx, "_res_exp"}, res_exp, 0);
    chk({pfx, "_mac_exp"}, mac_exp_min, 0);
    chk({pfx, "_mac_prec"}, mac_precision, 0);
  endtask

  task automatic start_job(input logic [3:0] prec,
                           input logic [4:0] emin,
                           input int len, input int nar_at,
                           input bit wd);
    exp_t e;
    @(negedge clk);
    n_set = 0;
    n_valid = 0;
    elem_idx = 0;
    nar_idx = nar_at;
    e.acc = wd ? 32'd0 : 32'(5 * len);
    e.ex  = wd ? emin : 5'(int'(emin) + len);
    e.nar = (nar_at >= 0) && (nar_at < len);
    e.err = wd;
    sb_q.push_back(e);
    cfg_precision = prec;
    cfg_exp_min = emin;
    cfg_len = LW'(len);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input int len);
    logic [AW-1:0] a;
    logic          w;
    int            n;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      a = AW'($urandom);
      w = 1'($urandom);
      in_act = a;
      in_w = w;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) begin
        chk("feed_timeout", in_ready, 1);
      end else begin
        @(posedge clk);
        #1;
        chk("mac_act", mac_act, a);
        chk("mac_w", mac_w, w);
      end
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_result(input int nv, input int hold);
    int   n;
    exp_t e;
    n = 0;
    while (!res_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("res_wait", res_valid, 1);
    if (res_valid) begin
      e = sb_q.pop_front();
      chk("res_acc", res_acc, e.acc);
      chk("res_exp", res_exp, e.ex);
      chk("res_nar", res_nar, e.nar);
      chk("res_err", res_err, e.err);
      chk("n_mac_set", n_set, 1);
      chk("n_mac_valid", n_valid, nv);
      for (int i = 0; i < hold; i++) begin
        start = 1'b1;
        @(negedge clk);
        chk("hold_valid", res_valid, 1);
        chk("hold_busy", busy, 1);
        chk("hold_acc", res_acc, e.acc);
        chk("hold_exp", res_exp, e.ex);
      end
      res_ready = 1'b1;
      start = (hold > 0);
      @(negedge clk);
      res_ready = 1'b0;
      start = 1'b0;
      chk("done_busy", busy, 0);
      chk("done_valid", res_valid, 0);
    end
  endtask

  initial begin
    exp_t drop;
    int   k;
    rst = 1'b1;
    start = 1'b0;
    cfg_precision = '0;
    cfg_exp_min = '0;
    cfg_len = '0;
    in_valid = 1'b0;
    in_act = '0;
    in_w = 1'b0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset("rst0");

    start_job(4'd4, 5'd2, 3, -1, 1'b0);
    feed(3);
    wait_result(3, 0);
    chk("prec_held", mac_precision, 4);

    start_job(4'd7, 5'd2, 0, -1, 1'b0);
    wait_result(0, 0);

    start_job(4'd2, 5'd1, 4, 1, 1'b0);
    feed(4);
    wait_result(4, 0);

    start_job(4'd3, 5'd6, 2, -1, 1'b0);
    feed(2);
    wait_result(2, 5);

    start_job(4'd9, 5'd3, 3, -1, 1'b0);
    feed(1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset("rst_wait");
    drop = sb_q.pop_front();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("late_busy", busy, 0);
      chk("late_valid", res_valid, 0);
    end
    chk("late_acc", mac_fixed_point_acc, 0);

`ifdef POSIT_MAC_SEQ_WATCHDOG_EN
    hold_done = 1;
    start_job(4'd1, 5'd4, 1, -1, 1'b1);
    feed(1);
    @(negedge clk);
    chk("wd_mac_valid", mac_valid, 1);
    k = 0;
    while (!res_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("wd_latency", k, TO + 1);
    wait_result(1, 0);
    hold_done = 0;
`else
    k = 0;
`endif

    start_job(4'd5, 5'd0, 1, -1, 1'b0);
    feed(1);
    wait_result(1, 0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
